// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_MAX_WIDTH = 16;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bi with borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bflop_q, bflop_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             d_bit, bo_bit;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .bi (bflop_q),
    .d  (d_bit),
    .bo (bo_bit)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bflop_d  = bflop_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          res_sr_d = '0;
          bflop_d  = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
          amsb_d   = a[WIDTH-1];
          bmsb_d   = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = {d_bit, res_sr_q[WIDTH-1:1]};
        bflop_d  = bo_bit;
        // Hold the counter on the last bit so it never wraps.
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        diff_d   = res_sr_q;
        borrow_d = bflop_q;
        busy_d   = 1'b0;
        state_d  = IDLE;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d    = (amsb_q ^ bmsb_q) & (amsb_q ^ res_sr_q[WIDTH-1]);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bflop_q  <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bflop_q  <= bflop_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign busy   = busy_q;
  assign done   = done_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: timeline reference model checked every cycle, plus directed literal scenarios.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] diff;
  logic         borrow, busy, done;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .diff   (diff),
    .borrow (borrow),
    .busy   (busy),
    .done   (done)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ovf_fn(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    r = x - y;
    return (x[W-1] != y[W-1]) && (x[W-1] != r[W-1]);
  endfunction

  // Reference model: ph counts cycles since the accepted start (0 = idle).
  int           ph = 0;
  logic [W-1:0] pa = '0, pb = '0;
  logic [W-1:0] m_diff = '0;
  logic         m_borrow = 1'b0;
  logic         m_ovf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ph       <= 0;
      m_diff   <= '0;
      m_borrow <= 1'b0;
      m_ovf    <= 1'b0;
    end else if (ph == 0) begin
      if (start) begin
        ph <= 1;
        pa <= a;
        pb <= b;
      end
    end else if (ph == W + 1) begin
      ph       <= 0;
      m_diff   <= pa - pb;
      m_borrow <= (pa < pb);
      m_ovf    <= ovf_fn(pa, pb);
    end else begin
      ph <= ph + 1;
    end
  end

  always @(negedge clk) begin
    check("model_busy", {31'd0, busy}, {31'd0, ph != 0});
    check("model_done", {31'd0, done}, {31'd0, ph == W + 1});
    check("model_diff", {24'd0, diff}, {24'd0, m_diff});
    check("model_borrow", {31'd0, borrow}, {31'd0, m_borrow});
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("model_ovf", {31'd0, ovf}, {31'd0, m_ovf});
`endif
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] ed, input logic eb, input string nm);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
      end
      if (k == W + 1) check({nm, "_done_pulse"}, {31'd0, done}, 32'd1);
    end
    check({nm, "_diff"}, {24'd0, diff}, {24'd0, ed});
    check({nm, "_borrow"}, {31'd0, borrow}, {31'd0, eb});
    check({nm, "_busy_low"}, {31'd0, busy}, 32'd0);
    check({nm, "_done_low"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    int nidle;

    // Pin the model's overflow rule with hand-worked values.
    check("pin_ovf_80_01", {31'd0, ovf_fn(8'h80, 8'h01)}, 32'd1);
    check("pin_ovf_5a_23", {31'd0, ovf_fn(8'h5A, 8'h23)}, 32'd0);

    repeat (3) @(negedge clk);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_borrow", {31'd0, borrow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    run_op(8'h5A, 8'h23, 8'h37, 1'b0, "basic");
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, "underflow");
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "equal");
    run_op(8'h00, 8'hFF, 8'h01, 1'b1, "zero_minus_ff");
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, "signed_ovf");
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("signed_ovf_flag", {31'd0, ovf}, 32'd1);
`endif

    // Start while busy is ignored, and late operand changes have no effect.
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 4) begin a = 8'hFF; b = 8'h77; start = 1'b1; end
      if (done) ndone++;
    end
    check("busy_ignore_ndone", ndone, 32'd1);
    check("busy_ignore_diff", {24'd0, diff}, 32'h0F);

    // Reset mid-operation discards the partial result.
    @(negedge clk);
    a = 8'h44; b = 8'h11; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5) rst = 1'b1;
      if (k == 6) rst = 1'b0;
    end
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_diff", {24'd0, diff}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    run_op(8'h44, 8'h11, 8'h33, 1'b0, "after_rst");

    // Start held high: done every W+2 cycles, one idle cycle in between.
    @(negedge clk);
    start = 1'b1; a = 8'h21; b = 8'h12;
    ndone = 0; nidle = 0;
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      if (done) begin
        ndone++;
        check("b2b_done_phase", k % (W + 2), W + 1);
      end
      if (!busy) nidle++;
    end
    check("b2b_ndone", ndone, 32'd3);
    check("b2b_nidle", nidle, 32'd2);
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Random traffic with occasional resets, judged by the model.
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a = W'($urandom);
      b = W'($urandom);
      rst = ($urandom_range(0, 80) == 0);
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
